// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer: buffers register writebacks in a FIFO and issues one-hot writes with read forwarding
//   clk/clr                      clock, async active-high reset
//   req_valid/req_ready          writeback request handshake (req_addr, req_data)
//   stall                        hold head entry, no write this cycle
//   drain_req/drain_done         quiesce request level / completion pulse
//   wr_en/wr_data                one-hot write enable and shared data to the register array
//   rd_addr1/2, fwd_hit1/2, fwd_data1/2  read-after-write forwarding from pending entries
//   pending                      FIFO occupancy
module regfile_wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     stall,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [2**ADDR_W-1:0]     wr_en,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2**ADDR_W;
  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push, pop;
  // register 0 is hardwired zero, so its requests complete the handshake but are dropped
  assign push = req_valid && req_ready && req_addr != '0;
  assign pop = cnt_q != '0 && !stall;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = req_addr;
      data_d[tail_q] = req_data;
    end
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
  // the entry pops on the same edge the array captures it
  assign wr_en = pop ? NR'(1) << addr_q[head_q] : '0;
  assign wr_data = pop ? data_q[head_q] : '0;
  assign pending = cnt_q;
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    fwd_hit1 = 1'b0;
    fwd_data1 = '0;
    fwd_hit2 = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < cnt_q) begin
        if (rd_addr1 != '0 && addr_q[head_q + PW'(k)] == rd_addr1) begin
          fwd_hit1 = 1'b1;
          fwd_data1 = data_q[head_q + PW'(k)];
        end
        if (rd_addr2 != '0 && addr_q[head_q + PW'(k)] == rd_addr2) begin
          fwd_hit2 = 1'b1;
          fwd_data2 = data_q[head_q + PW'(k)];
        end
      end
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= RUN;
    else state_q <= state_d;
  end
  // dropping drain_req mid-drain still empties the FIFO but skips the completion pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   state_d = drain_req ? DRAIN : RUN;
      DRAIN: state_d = cnt_q != '0 ? DRAIN : drain_req ? DONE : RUN;
      DONE:  state_d = HOLD;
      HOLD:  state_d = drain_req ? HOLD : RUN;
      default: state_d = RUN;
    endcase
  end
  always_comb begin
    req_ready = state_q == RUN && cnt_q < (PW+1)'(DEPTH);
    drain_done = state_q == DONE;
  end
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb_regfile_wb_sequencer: directed vector table plus hand-written drain, backpressure and reset sequences
module tb_regfile_wb_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic req_valid = 1'b0;
  logic stall = 1'b0;
  logic drain_req = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] req_data = '0;
  logic req_ready, drain_done, fwd_hit1, fwd_hit2;
  logic [2**AW-1:0] wr_en;
  logic [DW-1:0] wr_data, fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] pending;
  int errs = 0;
  int checks = 0;
  regfile_wb_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .stall(stall), .drain_req(drain_req),
    .drain_done(drain_done), .wr_en(wr_en), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  typedef struct {
    logic rv; logic [4:0] a; logic [31:0] d; logic st; logic dr; logic [4:0] r1; logic [4:0] r2;
    logic rdy; logic [31:0] we; logic [31:0] wd; logic h1; logic [31:0] d1; logic h2; logic [31:0] d2;
    logic [2:0] pend; logic done;
  } vec_t;
  vec_t v [15];
  initial begin
    v[0]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{0, 0, 0, 0, 0, 5, 7,  1, 32'h20, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 1, 0};
    v[3]  = '{0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4]  = '{1, 3, 32'h11, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[5]  = '{1, 3, 32'h22, 1, 0, 3, 0,  1, 0, 0, 1, 32'h11, 0, 0, 1, 0};
    v[6]  = '{0, 0, 0, 1, 0, 3, 7,  1, 0, 0, 1, 32'h22, 0, 0, 2, 0};
    v[7]  = '{0, 0, 0, 0, 0, 3, 3,  1, 32'h8, 32'h11, 1, 32'h22, 1, 32'h22, 2, 0};
    v[8]  = '{0, 0, 0, 0, 0, 3, 0,  1, 32'h8, 32'h22, 1, 32'h22, 0, 0, 1, 0};
    v[9]  = '{1, 0, 32'hFFFF, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[10] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[11] = '{1, 9, 32'h99, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[12] = '{1, 10, 32'hAA, 0, 0, 10, 0,  1, 32'h200, 32'h99, 0, 0, 0, 0, 1, 0};
    v[13] = '{0, 0, 0, 0, 0, 10, 0,  1, 32'h400, 32'hAA, 1, 32'hAA, 0, 0, 1, 0};
    v[14] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    #1 chk("rst.pend", pending, 0);
    chk("rst.wr_en", wr_en, 0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req_valid = v[i].rv; req_addr = v[i].a; req_data = v[i].d;
      stall = v[i].st; drain_req = v[i].dr; rd_addr1 = v[i].r1; rd_addr2 = v[i].r2;
      #1;
      chk($sformatf("v%0d.ready", i), req_ready, v[i].rdy);
      chk($sformatf("v%0d.wr_en", i), wr_en, v[i].we);
      chk($sformatf("v%0d.wr_data", i), wr_data, v[i].wd);
      chk($sformatf("v%0d.hit1", i), fwd_hit1, v[i].h1);
      chk($sformatf("v%0d.data1", i), fwd_data1, v[i].d1);
      chk($sformatf("v%0d.hit2", i), fwd_hit2, v[i].h2);
      chk($sformatf("v%0d.data2", i), fwd_data2, v[i].d2);
      chk($sformatf("v%0d.pend", i), pending, v[i].pend);
      chk($sformatf("v%0d.done", i), drain_done, v[i].done);
    end
    // backpressure: stalled FIFO fills at 4, fifth request refused
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = AW'(i + 1); req_data = 32'h101 + i; stall = 1'b1;
      rd_addr1 = '0; rd_addr2 = '0;
      #1;
      chk($sformatf("bp%0d.ready", i), req_ready, (i < 4) ? 1 : 0);
      chk($sformatf("bp%0d.pend", i), pending, (i < 4) ? i : 4);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      req_valid = 1'b0; stall = 1'b0;
      #1;
      chk($sformatf("bpw%0d.wr_en", j), wr_en, 64'(1) << (j + 1));
      chk($sformatf("bpw%0d.wr_data", j), wr_data, 32'h101 + j);
      chk($sformatf("bpw%0d.pend", j), pending, 4 - j);
    end
    @(negedge clk);
    #1 chk("bp.empty", pending, 0);
    chk("bp.ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 5'd5; req_data = 32'h105;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("bp5.wr_en", wr_en, 32'h20);
    chk("bp5.wr_data", wr_data, 32'h105);
    // drain with three pending writes
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = AW'(6 + i); req_data = 32'h60 + i; stall = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0; drain_req = 1'b1;
    #1 chk("dr.run_ready", req_ready, 1);
    chk("dr.pend3", pending, 3);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      stall = 1'b0; req_valid = 1'b1; req_addr = 5'd20; req_data = 32'hBAD;
      #1;
      chk($sformatf("dr%0d.ready", j), req_ready, 0);
      chk($sformatf("dr%0d.wr_en", j), wr_en, 64'(1) << (6 + j));
      chk($sformatf("dr%0d.wr_data", j), wr_data, 32'h60 + j);
      chk($sformatf("dr%0d.pend", j), pending, 3 - j);
      chk($sformatf("dr%0d.done", j), drain_done, 0);
    end
    @(negedge clk);
    #1 chk("dr.empty_pend", pending, 0);
    chk("dr.empty_done", drain_done, 0);
    chk("dr.empty_wr_en", wr_en, 0);
    @(negedge clk);
    #1 chk("dr.pulse", drain_done, 1);
    chk("dr.pulse_ready", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("hold%0d.done", k), drain_done, 0);
      chk($sformatf("hold%0d.ready", k), req_ready, 0);
      chk($sformatf("hold%0d.pend", k), pending, 0);
    end
    @(negedge clk);
    req_valid = 1'b0; drain_req = 1'b0;
    #1 chk("hold.exit_ready", req_ready, 0);
    @(negedge clk);
    #1 chk("run.ready", req_ready, 1);
    chk("run.done", drain_done, 0);
    // drain_req withdrawn mid-drain: entry still issued, no pulse
    req_valid = 1'b1; req_addr = 5'd12; req_data = 32'hC; stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; drain_req = 1'b1;
    #1 chk("ab.pend", pending, 1);
    @(negedge clk);
    drain_req = 1'b0;
    #1 chk("ab.ready", req_ready, 0);
    chk("ab.stalled", wr_en, 0);
    @(negedge clk);
    stall = 1'b0;
    #1 chk("ab.wr_en", wr_en, 32'h1000);
    @(negedge clk);
    #1 chk("ab.empty_done", drain_done, 0);
    chk("ab.empty_ready", req_ready, 0);
    @(negedge clk);
    #1 chk("ab.run_ready", req_ready, 1);
    chk("ab.run_done", drain_done, 0);
    // asynchronous clear with pending writes
    req_valid = 1'b1; req_addr = 5'd17; req_data = 32'h17; stall = 1'b1;
    @(negedge clk);
    req_addr = 5'd18; req_data = 32'h18;
    @(negedge clk);
    req_valid = 1'b0; stall = 1'b0; rd_addr1 = 5'd18;
    #1 chk("clr.pre_wr_en", wr_en, 32'h20000);
    chk("clr.pre_hit", fwd_hit1, 1);
    chk("clr.pre_pend", pending, 2);
    #2 clr = 1'b1;
    #1 chk("clr.pend", pending, 0);
    chk("clr.wr_en", wr_en, 0);
    chk("clr.wr_data", wr_data, 0);
    chk("clr.ready", req_ready, 1);
    chk("clr.hit1", fwd_hit1, 0);
    chk("clr.data1", fwd_data1, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    #1 chk("clr.after_pend", pending, 0);
    chk("clr.after_wr_en", wr_en, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
